// File: rtl/port_sweep_capture_if.sv
// port_sweep_capture_if
//   Bundles the sweep request, core port connections, result read port and
//   status outputs of port_sweep_capture.
//   slave  : the sequencer side (drives p3_drv_o, rd_data and the status bits).
//   master : the controlling side (drives start, p1_i/p2_i and rd_addr).
//   Signals:
//     start          sweep request, sampled each cycle
//     p1_i, p2_i     8-bit port values coming from the core
//     p3_drv_o       8-bit stimulus value going to the core
//     rd_addr        result read address (ADDR_W bits)
//     rd_data        registered {p2,p1} result
//     busy, done     sweep status
//     capture_strobe one-cycle pulse per stored result
//     cap_index      index of the last stored result
interface port_sweep_capture_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic [7:0]        p1_i;
    logic [7:0]        p2_i;
    logic [7:0]        p3_drv_o;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data;
    logic              busy;
    logic              done;
    logic              capture_strobe;
    logic [ADDR_W-1:0] cap_index;

    modport slave (
        input  start, p1_i, p2_i, rd_addr,
        output p3_drv_o, rd_data, busy, done, capture_strobe, cap_index
    );

    modport master (
        output start, p1_i, p2_i, rd_addr,
        input  p3_drv_o, rd_data, busy, done, capture_strobe, cap_index
    );
endinterface

// File: rtl/port_sweep_capture.sv
// port_sweep_capture
//   Stimulus/capture sequencer for a microcontroller core. After a start
//   request and START_DELAY cycles it sweeps p3 through 0..NUM_VECTORS-1,
//   holding each value SETTLE_CYCLES cycles before storing {p2,p1} into an
//   internal result memory. A tail of SETTLE_CYCLES cycles follows the last
//   capture, then done is raised. Results are read through a registered
//   read port with one cycle of latency.
//   Ports:
//     clk    rising-edge system clock
//     reset  synchronous, active-high reset (clears state and result memory)
//     bus    port_sweep_capture_if.slave (start, p1_i, p2_i, p3_drv_o,
//            rd_addr, rd_data, busy, done, capture_strobe, cap_index)
module port_sweep_capture #(
    parameter int START_DELAY   = 35000,
    parameter int SETTLE_CYCLES = 200,
    parameter int NUM_VECTORS   = 21,
    parameter int ADDR_W        = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    port_sweep_capture_if.slave  bus
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int CNT_MAX = (START_DELAY > SETTLE_CYCLES) ? START_DELAY : SETTLE_CYCLES;
    // The counter only ever reaches CNT_MAX-1.
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  DELAY_LAST  = CNT_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST    = ADDR_W'(NUM_VECTORS - 1);
    localparam logic [ADDR_W:0]   NUM_V       = (ADDR_W + 1)'(NUM_VECTORS);

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        SETTLE,
        TAIL,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic [7:0]        p3_reg, p3_next;
    logic [ADDR_W-1:0] cap_index_reg, cap_index_next;
    logic              strobe_reg, strobe_next;
    logic              done_reg, done_next;
    logic              capture;
    logic [15:0]       rd_data_reg;
    logic [15:0]       mem [DEPTH];

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            p3_reg        <= '0;
            cap_index_reg <= '0;
            strobe_reg    <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            p3_reg        <= p3_next;
            cap_index_reg <= cap_index_next;
            strobe_reg    <= strobe_next;
            done_reg      <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        idx_next       = idx_reg;
        p3_next        = p3_reg;
        cap_index_next = cap_index_reg;
        strobe_next    = 1'b0;
        done_next      = done_reg;
        capture        = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                // p3 keeps its last value until the sweep actually begins.
                if (bus.start) begin
                    done_next = 1'b0;
                    cnt_next  = '0;
                    if (START_DELAY == 0) begin
                        state_next = SETTLE;
                        idx_next   = '0;
                        p3_next    = '0;
                    end else begin
                        state_next = DELAY;
                    end
                end
            end

            DELAY: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == DELAY_LAST) begin
                    state_next = SETTLE;
                    idx_next   = '0;
                    p3_next    = '0;
                    cnt_next   = '0;
                end
            end

            SETTLE: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == SETTLE_LAST) begin
                    capture        = 1'b1;
                    strobe_next    = 1'b1;
                    cap_index_next = idx_reg;
                    cnt_next       = '0;
                    if (idx_reg == IDX_LAST) begin
                        state_next = TAIL;
                    end else begin
                        idx_next = idx_reg + ADDR_W'(1);
                        p3_next  = 8'(idx_reg + ADDR_W'(1));
                    end
                end
            end

            TAIL: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == SETTLE_LAST) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                    cnt_next   = '0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Result memory with registered read. Reset clears every entry so a
    // reset-aborted sweep never leaves stale results visible. The read
    // samples the array before this edge's write lands, so a same-edge
    // read/write returns the old value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data_reg <= '0;
        end else begin
            if (capture) begin
                mem[idx_reg] <= {bus.p2_i, bus.p1_i};
            end
            rd_data_reg <= ({1'b0, bus.rd_addr} < NUM_V) ? mem[bus.rd_addr] : 16'h0000;
        end
    end

    assign bus.p3_drv_o       = p3_reg;
    assign bus.rd_data        = rd_data_reg;
    assign bus.busy           = (state_reg == DELAY) || (state_reg == SETTLE) || (state_reg == TAIL);
    assign bus.done           = done_reg;
    assign bus.capture_strobe = strobe_reg;
    assign bus.cap_index      = cap_index_reg;

endmodule

// File: tb/tb_port_sweep_capture.sv
module tb_port_sweep_capture;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    port_sweep_capture_if #(.ADDR_W(5)) bus ();
    port_sweep_capture_if #(.ADDR_W(5)) bus0 ();

    // Main instance: small parameters.
    port_sweep_capture #(
        .START_DELAY  (4),
        .SETTLE_CYCLES(3),
        .NUM_VECTORS  (4),
        .ADDR_W       (5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Second instance: zero startup delay.
    port_sweep_capture #(
        .START_DELAY  (0),
        .SETTLE_CYCLES(3),
        .NUM_VECTORS  (4),
        .ADDR_W       (5)
    ) dut0 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus0)
    );

    // Combinational stand-in for the core: p1 = p3+1, p2 = ~p3.
    assign bus.p1_i  = bus.p3_drv_o + 8'd1;
    assign bus.p2_i  = ~bus.p3_drv_o;
    assign bus0.p1_i = bus0.p3_drv_o + 8'd1;
    assign bus0.p2_i = ~bus0.p3_drv_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full sweep on the main instance starting from IDLE with p3 = 0 and
    // cap_index = 0. Optional start pulses at edges 8 and 12 must be ignored.
    task automatic run_sweep(input string name, input bit inject);
        logic [7:0] exp_p3;
        logic [4:0] exp_cap;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({name, " busy@0"}, 32'(bus.busy), 32'd1);
        for (int e = 1; e <= 20; e++) begin
            bus.start = inject && (e == 8 || e == 12);
            tick();
            bus.start = 1'b0;
            exp_p3  = (e >= 13) ? 8'd3 : (e >= 10) ? 8'd2 : (e >= 7) ? 8'd1 : 8'd0;
            exp_cap = (e >= 16) ? 5'd3 : (e >= 13) ? 5'd2 : (e >= 10) ? 5'd1 : 5'd0;
            check($sformatf("%s p3@%0d", name, e), 32'(bus.p3_drv_o), 32'(exp_p3));
            check($sformatf("%s strobe@%0d", name, e), 32'(bus.capture_strobe),
                  32'(e == 7 || e == 10 || e == 13 || e == 16));
            check($sformatf("%s cap_index@%0d", name, e), 32'(bus.cap_index), 32'(exp_cap));
            check($sformatf("%s busy@%0d", name, e), 32'(bus.busy), 32'(e < 19));
            check($sformatf("%s done@%0d", name, e), 32'(bus.done), 32'(e >= 19));
        end
    endtask

    task automatic read_check(input string name, input logic [4:0] addr, input logic [15:0] exp);
        bus.rd_addr = addr;
        tick();
        check($sformatf("%s rd[%0d]", name, addr), 32'(bus.rd_data), 32'(exp));
    endtask

    initial begin
        logic [15:0] golden [4];
        logic [7:0]  exp_p3;
        golden[0] = 16'hFF01;
        golden[1] = 16'hFE02;
        golden[2] = 16'hFD03;
        golden[3] = 16'hFC04;
        vectors     = 0;
        miscompares = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.rd_addr  = '0;
        bus0.start   = 1'b0;
        bus0.rd_addr = '0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("reset p3", 32'(bus.p3_drv_o), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset strobe", 32'(bus.capture_strobe), 32'd0);
        check("reset cap_index", 32'(bus.cap_index), 32'd0);
        check("reset rd_data", 32'(bus.rd_data), 32'd0);

        // First sweep with ignored start pulses during SETTLE
        run_sweep("sweep1", 1'b1);
        for (int a = 0; a < 4; a++) read_check("sweep1", 5'(a), golden[a]);
        read_check("oob", 5'd4, 16'h0000);
        read_check("oob", 5'd31, 16'h0000);
        check("done holds", 32'(bus.done), 32'd1);
        check("p3 holds", 32'(bus.p3_drv_o), 32'd3);

        // Restart from DONE, then reset after the second capture
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart done", 32'(bus.done), 32'd0);
        check("restart busy", 32'(bus.busy), 32'd1);
        check("restart p3", 32'(bus.p3_drv_o), 32'd3);
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_p3 = (e >= 10) ? 8'd2 : (e >= 7) ? 8'd1 : (e >= 4) ? 8'd0 : 8'd3;
            check($sformatf("restart p3@%0d", e), 32'(bus.p3_drv_o), 32'(exp_p3));
            check($sformatf("restart strobe@%0d", e), 32'(bus.capture_strobe), 32'(e == 7 || e == 10));
        end
        check("restart cap_index", 32'(bus.cap_index), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort p3", 32'(bus.p3_drv_o), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort strobe", 32'(bus.capture_strobe), 32'd0);
        check("abort cap_index", 32'(bus.cap_index), 32'd0);
        check("abort rd_data", 32'(bus.rd_data), 32'd0);
        for (int a = 0; a < 4; a++) read_check("abort", 5'(a), 16'h0000);
        tick();
        check("abort idle", 32'(bus.busy), 32'd0);

        // Full sweep again after the abort
        run_sweep("sweep2", 1'b0);
        for (int a = 0; a < 4; a++) read_check("sweep2", 5'(a), golden[a]);

        // Zero startup delay instance
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        check("nodelay p3@0", 32'(bus0.p3_drv_o), 32'd0);
        check("nodelay busy@0", 32'(bus0.busy), 32'd1);
        for (int e = 1; e <= 4; e++) begin
            tick();
            check($sformatf("nodelay strobe@%0d", e), 32'(bus0.capture_strobe), 32'(e == 3));
            check($sformatf("nodelay p3@%0d", e), 32'(bus0.p3_drv_o), (e >= 3) ? 32'd1 : 32'd0);
        end
        bus0.rd_addr = 5'd0;
        tick();
        check("nodelay rd[0]", 32'(bus0.rd_data), 32'h0000FF01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
